// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM stage: bus structs, FSM state,
// opcode/funct3 encodings and the byte-enable width.
package mem_access_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    // Opcode encodings shared with the rest of the pipeline
    localparam logic [6:0] ALUopR = 7'b0110011;
    localparam logic [6:0] ALUopI = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] store_data;
    } ex_mem_bus_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] wb_value;
    } mem_wb_bus_t;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Combinational load extraction: selects the addressed byte/half/word from a
// returned memory word and sign- or zero-extends it.
module load_align_unit
    import mem_access_stage_pkg::*;
(
    input  logic [DATA_W-1:0] rsp_data_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        funct3_i,
    output logic [DATA_W-1:0] wb_value_o
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = rsp_data_i >> {off_i, 3'b000};
        case (funct3_i)
            F3_LB:   wb_value_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   wb_value_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  wb_value_o = {24'b0, shifted[7:0]};
            F3_LHU:  wb_value_o = {16'b0, shifted[15:0]};
            F3_LW:   wb_value_o = shifted;
            default: wb_value_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Multi-cycle MEM stage: valid/ready data-memory requests, byte-lane stores,
// aligned load extraction, misalignment and response-timeout faults.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  ex_mem_bus_t       ex_mem_bus_in,
    input  logic              in_valid,
    output logic              stall,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [BE_W-1:0]   dmem_be,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rsp_data,
    output mem_wb_bus_t       mem_wb_bus_out,
    output logic              out_valid,
    output logic              fault
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("mem_access_stage: XLEN must be 32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("mem_access_stage: TIMEOUT_CYCLES must be at least 2");
    end

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, fault_q;
    mem_wb_bus_t       mem_wb_q;

    logic              is_load, is_store, is_alu, is_mem, misaligned, mem_go;
    logic [1:0]        off;
    logic              tmo_hit, complete, fault_c;
    logic [XLEN-1:0]   wb_c, load_value;

    always_comb begin
        off        = ex_mem_bus_in.alu_result[1:0];
        is_load    = (ex_mem_bus_in.opcode == LW);
        is_store   = (ex_mem_bus_in.opcode == SW);
        is_alu     = (ex_mem_bus_in.opcode == ALUopR) || (ex_mem_bus_in.opcode == ALUopI);
        is_mem     = is_load || is_store;
        misaligned = 1'b0;
        if (is_mem) begin
            // funct3[1:0] encodes access size for both loads and stores
            case (ex_mem_bus_in.funct3[1:0])
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = off[0];
                default: misaligned = (off != 2'b00);
            endcase
        end
        mem_go  = in_valid && is_mem && !misaligned;
        tmo_hit = (cnt_q == TMO_LAST);
    end

    always_comb begin
        dmem_addr  = {ex_mem_bus_in.alu_result[XLEN-1:2], 2'b00};
        dmem_we    = is_store;
        dmem_be    = '1;
        dmem_wdata = '0;
        if (is_store) begin
            case (ex_mem_bus_in.funct3)
                F3_SB: begin
                    dmem_be    = 4'b0001 << off;
                    dmem_wdata = {4{ex_mem_bus_in.store_data[7:0]}};
                end
                F3_SH: begin
                    dmem_be    = 4'b0011 << off;
                    dmem_wdata = {2{ex_mem_bus_in.store_data[15:0]}};
                end
                F3_SW:   dmem_wdata = ex_mem_bus_in.store_data;
                default: dmem_wdata = ex_mem_bus_in.store_data;
            endcase
        end
    end

    load_align_unit u_load_align (
        .rsp_data_i (dmem_rsp_data),
        .off_i      (off),
        .funct3_i   (ex_mem_bus_in.funct3),
        .wb_value_o (load_value)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            mem_wb_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= complete;
            fault_q     <= complete && fault_c;
            if (complete) begin
                mem_wb_q <= '{instruction: ex_mem_bus_in.instruction,
                              opcode:      ex_mem_bus_in.opcode,
                              rd:          ex_mem_bus_in.rd,
                              wb_value:    wb_c};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (mem_go) begin
                    if (!dmem_req_ready) state_d = REQ;
                    else if (is_load)    state_d = WAIT;
                end
            end
            REQ: begin
                if (dmem_req_ready) state_d = is_load ? WAIT : IDLE;
                else if (tmo_hit)   state_d = IDLE;
            end
            WAIT: begin
                if (dmem_rsp_valid || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Any state change (IDLE->REQ, IDLE->WAIT, REQ->WAIT) restarts the count
        cnt_d = '0;
        if (state_q != IDLE && state_d == state_q) cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        dmem_req_valid = 1'b0;
        complete       = 1'b0;
        fault_c        = 1'b0;
        wb_c           = '0;
        unique case (state_q)
            IDLE: begin
                dmem_req_valid = mem_go;
                if (in_valid && !mem_go) begin
                    complete = 1'b1;
                    fault_c  = is_mem;
                    wb_c     = is_alu ? ex_mem_bus_in.alu_result : '0;
                end else if (mem_go && dmem_req_ready && is_store) begin
                    complete = 1'b1;
                end
            end
            REQ: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    complete = is_store;
                end else if (tmo_hit) begin
                    complete = 1'b1;
                    fault_c  = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_rsp_valid) begin
                    complete = 1'b1;
                    wb_c     = load_value;
                end else if (tmo_hit) begin
                    complete = 1'b1;
                    fault_c  = 1'b1;
                end
            end
            default: ;
        endcase
        if (reset) begin
            dmem_req_valid = 1'b0;
            complete       = 1'b0;
        end
        stall = mem_go && !complete;
    end

    assign mem_wb_bus_out = mem_wb_q;
    assign out_valid      = out_valid_q;
    assign fault          = fault_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM pipeline stage that replaces the single-cycle MEM stage. It sits between the EX/MEM bus and the MEM/WB bus and talks to data memory over a valid/ready request channel and a valid-only response channel. It adds several capabilities the single-cycle stage lacks:
- variable-latency memory with upstream stall;
- byte-lane store alignment with byte enables;
- unsigned loads (LBU/LHU);
- misalignment faults;
- a response timeout.

## Interface
Parameters:
- XLEN, 32: datapath width; only 32 is legal, checked by an elaboration assertion.
- TIMEOUT_CYCLES, 64: cycles spent in REQ+WAIT before the access is aborted with a fault. Must be at least 2.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- ex_mem_bus_in  in  ex_mem_bus_t  uses `opcode`, `funct3`, `rd`, `instruction`, `alu_result` (the effective address) and `store_data`.
- in_valid  in  1  the bus carries a live instruction.
- stall  out  1  upstream must hold `ex_mem_bus_in` and `in_valid` stable.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  word-aligned address, `{alu_result[31:2], 2'b00}`.
- dmem_wdata  out  XLEN  store data shifted into its byte lanes.
- dmem_be  out  4  byte enables.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rsp_data  in  XLEN  full word returned by memory.
- mem_wb_bus_out  out  mem_wb_bus_t  registered result carrying `instruction`, `opcode`, `rd` and `wb_value`.
- out_valid  out  1  `mem_wb_bus_out` holds a completed instruction.
- fault  out  1  the completed instruction faulted (misaligned access or timeout).

## Operation
- **Access classes.**
  - ALU ops (ALUopR, ALUopI): no memory access; `wb_value = alu_result`.
  - LW opcode: a load. Funct3 selects LB, LH, LW, LBU or LHU.
  - SW opcode: a store. Funct3 selects SB, SH or SW.
  - Any other opcode: passes through with `wb_value = 0`.
- **Alignment.** Let `off = alu_result[1:0]`.
  - LW/SW with `off != 0` is misaligned.
  - LH/LHU/SH with `off[0] = 1` is misaligned.
  - A misaligned access issues no memory request. It completes in the acceptance cycle with `fault = 1` and `wb_value = 0`.
- **Store lanes.**
  - SB: `be = 4'b0001 << off`; the low byte of `store_data` is replicated to all four lanes.
  - SH: `be = 4'b0011 << off`; the low half is replicated to both halves.
  - SW: `be = 4'b1111`.
  - Loads: `be = 4'b1111`.
- **Load extract.** Shift `rsp_data` right by `8*off`, then take the low byte or half. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word. Stores produce `wb_value = 0`.
- **FSM states: IDLE, REQ, WAIT.**
  - IDLE, aligned memory op with `in_valid`: assert `dmem_req_valid` combinationally. On ready, a store completes this cycle and a load moves to WAIT. Without ready, move to REQ.
  - REQ: hold `dmem_req_valid` and all request fields. On ready, a store completes and returns to IDLE; a load moves to WAIT.
  - WAIT: on `dmem_rsp_valid`, the load completes and returns to IDLE.
  - `dmem_rsp_valid` in IDLE or REQ is ignored.
- **Timeout.**
  - The counter clears on entry to REQ or WAIT and increments every cycle in those states.
  - When it reaches `TIMEOUT_CYCLES - 1`, the access completes with `fault = 1` and `wb_value = 0`, and the FSM returns to IDLE.
  - A response arriving in the same cycle as the timeout wins: normal completion, no fault.
- **Stall.** `stall = in_valid & is_mem_op & aligned & ~complete_this_cycle`. ALU ops, pass-through opcodes and misaligned ops never stall.

## Timing
- **Output register.** Loads on the completion cycle. `out_valid` is 1 for exactly one cycle, the cycle after completion; otherwise it is 0.
- **ALU op:** `out_valid` 1 cycle after acceptance, zero stall.
- **Store with ready in the same cycle:** zero stall, `out_valid` next cycle.
- **Load:** minimum 1 stall cycle. The response arrives at the earliest 1 cycle after the request handshake, so minimum latency is 2 cycles.
- **Back-to-back ops:** a new op is accepted in the cycle after completion. The FSM is in IDLE by then.
- **Reset** (also mid-access):
  - State goes to IDLE; the counter, `out_valid`, `fault` and `mem_wb_bus_out` all go to 0.
  - `dmem_req_valid` is 0 in the reset cycle.
  - A response for a request issued before reset is dropped, because it arrives in IDLE.
- **Request stability:** while `dmem_req_valid = 1` and `dmem_req_ready = 0`, addr, we, wdata and be must not change.

## Structure
- The shared package holds:
  - the FSM state enum `mem_state_t`;
  - funct3 constants for LBU, LHU, SB, SH and SW;
  - the localparam `BE_W = XLEN/8`.
- Opcode constants are reused from the existing opcodes file.
- One sub-module, `load_align_unit`, is purely combinational. It takes `rsp_data`, `off` and `funct3` and produces the extended `wb_value`. It is reused by a future cache.
- The store-lane logic and the FSM stay in `mem_access_stage`.

## Test plan
- **ALU pass-through:** ALUopR with `alu_result = 0x1234` -> no dmem activity, `out_valid` next cycle, `wb_value = 0x1234`, `stall = 0`.
- **SB lane placement:** SB at addr `0x103` with `store_data = 0xAB`, ready held high -> `be = 4'b1000`, `wdata = 0xABABABAB`, `addr = 0x100`, no stall.
- **Signed vs unsigned byte load:** LB at `0x102`, response `0x00F20000` 3 cycles after the handshake -> `stall` high for 3 cycles, `wb_value = 0xFFFFFFF2`. Repeating as LBU -> `0x000000F2`.
- **Misaligned load:** LW at `0x106` -> `dmem_req_valid` never asserted, `out_valid` next cycle, `fault = 1`, `wb_value = 0`.
- **Timeout:** `TIMEOUT_CYCLES = 4`, LH at `0x200`, no response -> `fault = 1` after 4 cycles in REQ/WAIT. A `rsp_valid` pulse 2 cycles later is ignored.
- **Reset mid-access:** reset asserted while in WAIT -> all outputs 0 next cycle. A following `rsp_valid` produces no `out_valid`.
